// File: rtl/vreg_pkg.sv
// Shared widths and write-request types for the vector register file write path.
package vreg_pkg;

    localparam int DEFAULT_REG_LEN  = 64;
    localparam int DEFAULT_NUM_REGS = 8;
    localparam int DEFAULT_ADDR_W   = $clog2(DEFAULT_NUM_REGS);

    typedef logic [DEFAULT_ADDR_W-1:0]  vreg_addr_t;
    typedef logic [DEFAULT_REG_LEN-1:0] vreg_data_t;

    typedef struct packed {
        vreg_addr_t addr;
        vreg_data_t data;
    } vreg_wr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot picker with its own priority pointer.
// The search starts one past the last winner; the pointer moves only on a grant.
module rr_arbiter #(
    parameter int  N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     valid_i,
    input  logic             en_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_d;

    // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int off = 1; off <= N; off++) begin
            cand = (int'(last_q) + off >= N) ? IDX_W'(int'(last_q) + off - N)
                                             : IDX_W'(int'(last_q) + off);
            if (!found && valid_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
        if (!en_i) begin
            grant_o = '0;
        end
    end

    assign last_d = (|grant_o) ? idx_o : last_q;

    // NOTE: state registers use non-blocking assignments; next-state logic stays in always_comb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IDX_W'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/vreg_write_arbiter.sv
// Shares the vector register file write port among NUM_REQ producers through a
// one-entry output stage; writes to register 0 are accepted but dropped and counted.
module vreg_write_arbiter
    import vreg_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int REG_LEN  = DEFAULT_REG_LEN,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             nreset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][REG_LEN-1:0]  req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic                             hold,
    output logic                             rf_write_en,
    output logic [ADDR_W-1:0]                rf_write_addr,
    output logic [REG_LEN-1:0]               rf_write_data,
    output logic [ID_W-1:0]                  grant_id,
    output logic [NUM_REGS-1:0]              busy_mask,
    output logic [7:0]                       drop_cnt
);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win_idx;
    logic               arb_en;

    logic               accept;
    logic [ADDR_W-1:0]  sel_addr;
    logic [REG_LEN-1:0] sel_data;

    logic               wen_q,  wen_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [REG_LEN-1:0] data_q, data_d;
    logic [ID_W-1:0]    gid_q,  gid_d;
    logic [7:0]         drop_q, drop_d;

    // Gating with nreset keeps req_ready low for the whole reset window.
    assign arb_en = ~hold & nreset;

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .clk     (clk),
        .rst_n   (nreset),
        .valid_i (req_valid),
        .en_i    (arb_en),
        .grant_o (grant),
        .idx_o   (win_idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign sel_addr  = req_addr[win_idx];
    assign sel_data  = req_data[win_idx];

    always_comb begin
        wen_d  = accept && (sel_addr != '0);
        addr_d = wen_d ? sel_addr : addr_q;
        data_d = wen_d ? sel_data : data_q;
        gid_d  = wen_d ? win_idx  : gid_q;
        drop_d = drop_q;
        if (accept && (sel_addr == '0) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // The output stage drains every cycle, so a new grant never has to wait for it.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wen_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            gid_q  <= '0;
            drop_q <= '0;
        end else begin
            wen_q  <= wen_d;
            addr_q <= addr_d;
            data_q <= data_d;
            gid_q  <= gid_d;
            drop_q <= drop_d;
        end
    end

    assign rf_write_en   = wen_q;
    assign rf_write_addr = addr_q;
    assign rf_write_data = data_q;
    assign grant_id      = gid_q;
    assign drop_cnt      = drop_q;
    assign busy_mask     = wen_q ? (NUM_REGS'(1) << addr_q) : '0;

endmodule

// File: tb/tb_vreg_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-level reference model of the round-robin write port.
module tb_vreg_write_arbiter;
    import vreg_pkg::*;

    localparam int NR  = 2;
    localparam int RL  = 64;
    localparam int NRG = 8;
    localparam int AW  = 3;

    logic                   clk = 1'b0;
    logic                   nreset = 1'b0;
    logic [NR-1:0]          req_valid = '0;
    logic [NR-1:0][AW-1:0]  req_addr = '0;
    logic [NR-1:0][RL-1:0]  req_data = '0;
    logic                   hold = 1'b0;
    logic [NR-1:0]          req_ready;
    logic                   rf_write_en;
    logic [AW-1:0]          rf_write_addr;
    logic [RL-1:0]          rf_write_data;
    logic                   grant_id;
    logic [NRG-1:0]         busy_mask;
    logic [7:0]             drop_cnt;

    always #5 clk = ~clk;

    vreg_write_arbiter #(
        .NUM_REQ(NR), .REG_LEN(RL), .NUM_REGS(NRG), .ADDR_W(AW)
    ) dut (
        .clk           (clk),
        .nreset        (nreset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .hold          (hold),
        .rf_write_en   (rf_write_en),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .grant_id      (grant_id),
        .busy_mask     (busy_mask),
        .drop_cnt      (drop_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: priority pointer, expected output stage, drop count, register file.
    int          m_last;
    bit          m_wen;
    int          m_addr;
    logic [63:0] m_data;
    int          m_gid;
    int          m_drop;
    logic [63:0] m_rf [NRG];
    logic [63:0] d_rf [NRG];
    int          last_win;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] v, input int last);
        for (int off = 1; off <= NR; off++) begin
            int c;
            c = (last + off) % NR;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last = NR - 1;
        m_wen  = 1'b0;
        m_addr = 0;
        m_data = '0;
        m_gid  = 0;
        m_drop = 0;
    endtask

    // One clock cycle: entered just after a falling edge with inputs already driven.
    task automatic cycle();
        int            w;
        logic [NR-1:0] exp_ready;
        logic [63:0]   exp_busy;
        if (!nreset) model_reset();
        w = (nreset && !hold) ? pick(req_valid, m_last) : -1;
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        exp_busy = m_wen ? (64'd1 << m_addr) : 64'd0;
        #1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("rf_write_en", 64'(rf_write_en), 64'(m_wen));
        check("rf_write_addr", 64'(rf_write_addr), 64'(m_addr));
        check("rf_write_data", rf_write_data, m_data);
        check("grant_id", 64'(grant_id), 64'(m_gid));
        check("busy_mask", 64'(busy_mask), exp_busy);
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (rf_write_en) d_rf[rf_write_addr] = rf_write_data;
        if (m_wen) m_rf[m_addr] = m_data;
        @(posedge clk);
        m_wen = 1'b0;
        if (nreset && w >= 0) begin
            m_last = w;
            if (req_addr[w] != '0) begin
                m_wen  = 1'b1;
                m_addr = int'(req_addr[w]);
                m_data = req_data[w];
                m_gid  = w;
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
        last_win = w;
        @(negedge clk);
    endtask

    task automatic drive(input bit v0, input int a0, input logic [63:0] d0,
                         input bit v1, input int a1, input logic [63:0] d1, input bit h);
        req_valid   = {v1, v0};
        req_addr[0] = AW'(a0);
        req_addr[1] = AW'(a1);
        req_data[0] = d0;
        req_data[1] = d1;
        hold        = h;
    endtask

    task automatic apply_reset();
        nreset = 1'b0;
        cycle();
        nreset = 1'b1;
    endtask

    vreg_wr_req_t pend [NR];
    bit           pv   [NR];

    initial begin
        for (int r = 0; r < NRG; r++) begin
            m_rf[r] = '0;
            d_rf[r] = '0;
        end
        model_reset();
        @(negedge clk);

        // Reset state, with requests present so req_ready must stay low.
        drive(1, 2, 64'h1, 1, 5, 64'h2, 0);
        cycle();
        cycle();
        nreset = 1'b1;

        // Single write from requester 1.
        apply_reset();
        drive(0, 0, 0, 1, 3, 64'hDEADBEEF_01234567, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("single_data_reg3", d_rf[3], 64'hDEADBEEF_01234567);

        // Continuous alternation, then a three-cycle hold.
        apply_reset();
        drive(1, 2, 64'hA2, 1, 5, 64'hB5, 0);
        repeat (6) cycle();
        drive(1, 2, 64'hA2, 1, 5, 64'hB5, 1);
        repeat (3) cycle();
        drive(1, 2, 64'hA2, 1, 5, 64'hB5, 0);
        repeat (3) cycle();

        // Three dropped writes to register 0, then requester 1 gets priority.
        apply_reset();
        drive(1, 0, 64'h77, 0, 0, 0, 0);
        repeat (3) cycle();
        check("drop_after_three", 64'(drop_cnt), 64'd3);
        drive(1, 0, 64'h77, 1, 1, 64'h11, 0);
        cycle();
        check("rr_after_drop", 64'(last_win), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Same destination from both requesters: the later grant wins.
        apply_reset();
        drive(1, 4, 64'hAAAA, 1, 4, 64'hBBBB, 0);
        cycle();
        drive(0, 4, 64'hAAAA, 1, 4, 64'hBBBB, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        check("same_addr_final", d_rf[4], 64'hBBBB);

        // Reset while the output stage holds a write to register 6.
        apply_reset();
        drive(1, 6, 64'h6666, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        nreset = 1'b0;
        cycle();
        nreset = 1'b1;
        check("lost_write_reg6", d_rf[6], 64'h0);
        drive(1, 1, 64'hC1, 1, 2, 64'hC2, 0);
        cycle();
        check("prio_after_reset", 64'(last_win), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Drop counter saturation.
        apply_reset();
        drive(1, 0, 64'h5, 0, 0, 0, 0);
        repeat (258) cycle();
        check("drop_saturated", 64'(drop_cnt), 64'd255);
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Random traffic with hold; requesters keep a request stable until accepted.
        apply_reset();
        for (int i = 0; i < NR; i++) pv[i] = 1'b0;
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pv[i] && ($urandom_range(1, 0) == 1)) begin
                    pv[i]        = 1'b1;
                    pend[i].addr = vreg_addr_t'($urandom_range(NRG - 1, 0));
                    pend[i].data = {$urandom, $urandom};
                end
                req_valid[i] = pv[i];
                req_addr[i]  = pend[i].addr;
                req_data[i]  = pend[i].data;
            end
            hold = ($urandom_range(4, 0) == 0);
            cycle();
            if (last_win >= 0) pv[last_win] = 1'b0;
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        for (int r = 0; r < NRG; r++) begin
            check($sformatf("rf_reg%0d", r), d_rf[r], m_rf[r]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/vreg_write_arbiter.md
# vreg_write_arbiter

Shares the single write port of the vector register file among several result producers (ALU, load unit, …). Each cycle it picks one valid requester round-robin, registers the winning write in a one-entry output stage, and drives the register file write port from that stage on the next cycle. It also exports a busy mask of the register being written, for the issue logic's hazard checks.

## Interface
Parameters:
- NUM_REQ, 2, number of write requesters (≥2)
- REG_LEN, 64, vector register width in bits
- NUM_REGS, 8, number of vector registers
- ADDR_W, $clog2(NUM_REGS), register address width

Ports:
- clk  in  1  single clock, all state on rising edge
- nreset  in  1  asynchronous, active-low reset
- req_valid  in  [NUM_REQ]  requester i holds a write
- req_addr  in  [NUM_REQ][ADDR_W]  destination register per requester
- req_data  in  [NUM_REQ][REG_LEN]  write data per requester
- req_ready  out  [NUM_REQ]  one-hot grant; write i accepted when valid&ready
- hold  in  1  blocks new grants this cycle (issue/scheduler stall)
- rf_write_en  out  1  register file write enable
- rf_write_addr  out  ADDR_W  register file write address
- rf_write_data  out  REG_LEN  register file write data
- grant_id  out  $clog2(NUM_REQ)  index of requester whose write is in the output stage
- busy_mask  out  [NUM_REGS]  bit r set while the output stage holds a write to r
- drop_cnt  out  8  saturating count of accepted writes to register 0

## Operation
- Round-robin pointer last: search order starts at last+1 and wraps modulo NUM_REQ; first valid requester wins.
- The pointer updates to the winner only on an accepted grant. hold or no valid requests leave it unchanged.
- req_ready is combinational: at most one bit high, only for the winner, forced 0 when hold=1 or during reset.
- Accepted write with addr≠0: output stage loads addr/data/id, and rf_write_en=1 the next cycle.
- Accepted write with addr=0: accepted (ready=1) but discarded. rf_write_en stays 0, busy_mask stays 0, drop_cnt increments and saturates at 255. The pointer still advances.
- The register file never back-pressures, so the output stage drains every cycle. A grant is therefore possible every cycle, giving full throughput.
- No accept in a cycle: rf_write_en=0 next cycle. addr, data and grant_id keep their last values.
- Same address from two requesters: writes commit in grant order, one per cycle. The later grant wins the final register value.
- Requesters must hold valid, addr and data stable until accepted. The arbiter does not check this.
- busy_mask equals onehot(rf_write_addr) when rf_write_en=1, else all zero.

## Timing
- Accept in cycle N: rf_write_en/addr/data valid in cycle N+1. The register file captures at the end of N+1 and the value is readable from N+2.
- Latency from request to port is 1 cycle. Throughput is 1 write/cycle.
- hold takes effect in the same cycle (combinational on req_ready). An output-stage write already loaded still commits.
- Reset (asynchronous, anytime) sets:
  - rf_write_en=0, rf_write_addr=0, rf_write_data=0
  - grant_id=0, busy_mask=0, drop_cnt=0
  - pointer last=NUM_REQ-1, so requester 0 has first priority
  - req_ready=0 while nreset=0
- Reset mid-operation: an in-flight output-stage write is lost and never reaches the register file.
- First grant possible in the first clock edge after nreset deasserts.

## Structure
- Package vreg_pkg holds:
  - REG_LEN, NUM_REGS and ADDR_W defaults
  - typedef vreg_addr_t
  - typedef vreg_data_t
  - struct vreg_wr_req_t {addr, data}
- Sub-module rr_arbiter(N): combinational one-hot pick from the valid vector and pointer, with the pointer register and its enable. It is reused later for read-port sharing.
- The top level contains rr_arbiter, the output stage, the drop counter and the busy-mask decode.

## Test plan
- Single requester 1 with addr=3, data=0xDEADBEEF_01234567 for 1 cycle → next cycle rf_write_en=1, addr=3, data matches, grant_id=1, busy_mask=0x08.
- Both requesters valid continuously (addr 2 and 5) after reset → grants alternate 0,1,0,1. rf_write_en stays high every cycle with addresses 2,5,2,5.
- Both valid, hold=1 for 3 cycles → req_ready=0 and rf_write_en=0 during the hold (after the stage drains). When hold drops, the grant goes to the requester after last.
- Requester 0 writes addr=0 three times → req_ready pulses three times, rf_write_en never rises, drop_cnt=3. Then requester 1 is granted next.
- Both target addr=4 with data A (req0) and B (req1) simultaneously from reset → A is written in cycle N+1 and B in N+2, so the register holds B.
- nreset asserted in the cycle the output stage holds a write to addr=6 → rf_write_en drops immediately, busy_mask=0. After release, requester 0 has priority.
